// File: rtl/debug_mem_dumper.sv
// -----------------------------------------------------------------------------
// debug_mem_dumper
//
// Debug-unit reader that sweeps every data-memory word while the pipeline is
// halted. Each word is streamed to the UART transmitter as four bytes, most
// significant byte first, in ascending address order.
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_rst          asynchronous active-low reset
//   i_start        dump request, only honoured while idle
//   o_mem_read_en  data-memory debug read enable (high only while reading)
//   o_mem_addr     data-memory word address (holds its last value)
//   i_mem_data     read data, valid one cycle after address/enable
//   o_tx_data      byte presented to the UART transmitter
//   o_tx_start     one-cycle pulse launching transmission of o_tx_data
//   i_tx_done      one-cycle pulse from the transmitter when a byte is sent
//   o_busy         high in every state except idle
//   o_done         one-cycle pulse after the last byte has been sent
// -----------------------------------------------------------------------------
module debug_mem_dumper #(
    parameter int LEN            = 32,
    parameter int RAM_DEPTH_DATA = 21,
    parameter int NB_MEM_ADDR    = 5,
    parameter int NB_BYTE        = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic                   o_mem_read_en,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [LEN-1:0]         i_mem_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Address of the final word; the counter stops here and never wraps.
    localparam logic [NB_MEM_ADDR-1:0] LAST_ADDR = NB_MEM_ADDR'(RAM_DEPTH_DATA - 1);

    state_t                 state_r;
    logic [NB_MEM_ADDR-1:0] addr_r;
    logic [1:0]             byte_cnt_r;
    logic [LEN-1:0]         word_r;
    logic                   mem_read_en_r;
    logic [NB_BYTE-1:0]     tx_data_r;
    logic                   tx_start_r;
    logic                   busy_r;
    logic                   done_r;

    // Byte picker: index 0 is the most significant byte of the word.
    function automatic logic [NB_BYTE-1:0] byte_sel(input logic [LEN-1:0] word,
                                                    input logic [1:0]     idx);
        case (idx)
            2'd0:    byte_sel = word[LEN-1 -: NB_BYTE];
            2'd1:    byte_sel = word[LEN-1-NB_BYTE -: NB_BYTE];
            2'd2:    byte_sel = word[LEN-1-2*NB_BYTE -: NB_BYTE];
            default: byte_sel = word[LEN-1-3*NB_BYTE -: NB_BYTE];
        endcase
    endfunction

    // Dump sequencer: state, counters, word buffer and every registered output.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r       <= ST_IDLE;
            addr_r        <= '0;
            byte_cnt_r    <= 2'd0;
            word_r        <= '0;
            mem_read_en_r <= 1'b0;
            tx_data_r     <= '0;
            tx_start_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_start_r <= 1'b0;
                    done_r     <= 1'b0;
                    if (i_start) begin
                        addr_r        <= '0;
                        byte_cnt_r    <= 2'd0;
                        mem_read_en_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ST_READ;
                    end else begin
                        mem_read_en_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Memory samples the address on this edge; data arrives in LATCH.
                    mem_read_en_r <= 1'b0;
                    state_r       <= ST_LATCH;
                end
                ST_LATCH: begin
                    // The first byte comes straight from the read port because
                    // word_r only becomes valid on this same edge.
                    word_r     <= i_mem_data;
                    byte_cnt_r <= 2'd0;
                    tx_data_r  <= byte_sel(i_mem_data, 2'd0);
                    tx_start_r <= 1'b1;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    // A done pulse coincident with the start pulse is not looked at.
                    tx_start_r <= 1'b0;
                    state_r    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (byte_cnt_r != 2'd3) begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            tx_data_r  <= byte_sel(word_r, byte_cnt_r + 2'd1);
                            tx_start_r <= 1'b1;
                            state_r    <= ST_SEND;
                        end else if (addr_r == LAST_ADDR) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            addr_r        <= addr_r + NB_MEM_ADDR'(1);
                            mem_read_en_r <= 1'b1;
                            state_r       <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_WAIT_TX;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: park safely in idle with outputs quiet.
                    mem_read_en_r <= 1'b0;
                    tx_start_r    <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_read_en = mem_read_en_r;
    assign o_mem_addr    = addr_r;
    assign o_tx_data     = tx_data_r;
    assign o_tx_start    = tx_start_r;
    assign o_busy        = busy_r;
    assign o_done        = done_r;

endmodule

// File: doc/debug_mem_dumper.md
# debug_mem_dumper

Read-side companion of the MIPS memory-access stage: while the pipeline is halted, it sweeps every word of data memory through a read port and streams each word as four bytes to the UART transmitter of the debug unit. The memory-access stage is the data-memory writer; this block is its reader toward the host. It sits in the debug unit, between the data-memory debug read port and the UART TX byte interface.

## Interface
- `LEN`, 32, data-memory word width
- `RAM_DEPTH_DATA`, 21, number of words dumped (addresses 0..RAM_DEPTH_DATA-1)
- `NB_MEM_ADDR`, 5, data-memory address width (must satisfy 2^NB_MEM_ADDR >= RAM_DEPTH_DATA)
- `NB_BYTE`, 8, UART byte width

Ports:
- `i_clk`  in  1  single clock; all state changes on the rising edge
- `i_rst`  in  1  reset, asynchronous and active-low
- `i_start`  in  1  dump request; sampled only in IDLE
- `o_mem_read_en`  out  1  data-memory debug read enable
- `o_mem_addr`  out  NB_MEM_ADDR  data-memory word address
- `i_mem_data`  in  LEN  read data; valid one cycle after address and enable are presented
- `o_tx_data`  out  NB_BYTE  byte to transmit
- `o_tx_start`  out  1  one-cycle pulse; launches transmission of `o_tx_data`
- `i_tx_done`  in  1  one-cycle pulse from TX when the byte has been fully sent
- `o_busy`  out  1  high in every state except IDLE
- `o_done`  out  1  one-cycle pulse after the last byte's `i_tx_done`

## Operation
- States: IDLE, READ, LATCH, SEND, WAIT_TX, DONE.
- IDLE:
  - `i_start`=1 clears the address counter and byte counter, then goes to READ.
  - Otherwise stays in IDLE.
- READ:
  - `o_mem_read_en`=1 and `o_mem_addr`=address counter.
  - Always goes to LATCH.
- LATCH:
  - `i_mem_data` is captured into a LEN-bit word register at the end of the cycle.
  - Byte counter is cleared.
  - Goes to SEND.
- SEND:
  - `o_tx_start`=1 for exactly this cycle.
  - `o_tx_data` = selected byte of the word, MSB first: byte 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - Goes to WAIT_TX.
- WAIT_TX:
  - `o_tx_data` is held stable until `i_tx_done`.
  - On `i_tx_done`:
    - byte counter < 3: increment it, go to SEND.
    - byte counter = 3 and address = RAM_DEPTH_DATA-1: go to DONE.
    - otherwise: increment address, go to READ.
- DONE: `o_done`=1 for one cycle, then IDLE.
- Total output per dump: 4·RAM_DEPTH_DATA bytes (84 with defaults), in ascending address order.
- Address counter never wraps; the last word read is exactly RAM_DEPTH_DATA-1.
- `o_mem_read_en` is high only in READ; `o_mem_addr` holds its last value elsewhere.

## Timing
- Reset (`i_rst`=0, any time, including mid-dump):
  - immediate return to IDLE, counters cleared;
  - all outputs 0: `o_mem_read_en`, `o_mem_addr`, `o_tx_data`, `o_tx_start`, `o_busy`, `o_done`.
  - A dump interrupted by reset is not resumed.
- Start latency: `i_start` sampled at edge k → READ during cycle k+1 → LATCH k+2 → first `o_tx_start` in cycle k+3.
- Between bytes of one word: `i_tx_done` sampled at edge j → next `o_tx_start` in cycle j+1.
- Between words: `i_tx_done` sampled at edge j → READ j+1, LATCH j+2, `o_tx_start` j+3.
- `i_tx_done` in the same cycle as `o_tx_start` (SEND) is ignored; it is honoured only in WAIT_TX.
- `i_tx_done` in any state other than WAIT_TX is ignored.
- `i_start` while `o_busy`=1 is ignored; it is neither queued nor a restart.
- `i_start` held high through DONE starts a new dump on the first IDLE cycle.
- `o_busy` rises the cycle after `i_start` is accepted and falls the cycle after `o_done`.

## Test plan
1. Memory model `mem[i] = 32'h01010101·i`, TX model returns `i_tx_done` 5 cycles after each `o_tx_start`, `i_start` pulse → 84 bytes in order 00,00,00,00,01,01,01,01,…,14,14,14,14; exactly one `o_done`; `o_busy` low afterwards.
2. `mem[1]=F6F6F6F6`, `mem[13]=A5DFA5DF`, TX done after 1 cycle → bytes 4–7 = F6, bytes 52–55 = A5,DF,A5,DF; first `o_tx_start` 3 cycles after `i_start`.
3. Second `i_start` pulse during byte 10 → stream unchanged, still 84 bytes, single `o_done`.
4. `i_rst` low during word 7 → all outputs 0 immediately; after release and a new `i_start`, dump restarts at address 0.
5. Spurious `i_tx_done` in IDLE and coincident with `o_tx_start` → no state advance; byte sequence identical to scenario 1.
6. Check `o_mem_read_en` pulses exactly 21 times with addresses 0..20, and `o_tx_data` is stable throughout every WAIT_TX interval.
